dm_arbiter: RTL and testbench

//  Shares the single-port data memory (DATA_SIZE x ADDRESSES, sync write / comb read)

---
 rtl/dm_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU port A and debug/DMA port B.
// Define DM_ARB_RR_EN for round-robin IDLE arbitration; default build is fixed priority (A over B).
module dm_arbiter #(
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned SELEC_SIZE = 16,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [SELEC_SIZE-1:0] a_addr,
   input  logic [DATA_SIZE-1:0]  a_wdata,
   input  logic                  a_lock,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_SIZE-1:0]  a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [SELEC_SIZE-1:0] b_addr,
   input  logic [DATA_SIZE-1:0]  b_wdata,
   input  logic                  b_lock,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_SIZE-1:0]  b_rdata,
   output logic                  dm_we,
   output logic [SELEC_SIZE-1:0] dm_address,
   output logic [DATA_SIZE-1:0]  dm_d,
   input  logic [DATA_SIZE-1:0]  dm_q
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;      // 1: B won most recently
   logic               force_q, force_d;    // forced release pending for next IDLE cycle
   logic               force_b_q, force_b_d; // port favoured by the forced release
   logic               win_a, win_b;
   logic [CNT_W-1:0]   beat_cnt;
   logic               beat_lock;

   logic               a_rvalid_q, b_rvalid_q;
   logic [DATA_SIZE-1:0] a_rdata_q, b_rdata_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         force_q   <= 1'b0;
         force_b_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         force_q   <= force_d;
         force_b_q <= force_b_d;
      end
   end

   // Next-state logic; ownership ends on lock=0, a missing request, or the burst cap
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      force_d   = 1'b0;
      force_b_d = force_b_q;
      beat_cnt  = (state_q == IDLE) ? CNT_W'(1) : CNT_W'(cnt_q + CNT_W'(1));
      beat_lock = a_gnt ? a_lock : b_lock;
      if (a_gnt || b_gnt) begin
         last_d = b_gnt;
         if (beat_lock && (beat_cnt < CNT_W'(MAX_BURST))) begin
            state_d = a_gnt ? OWN_A : OWN_B;
            cnt_d   = beat_cnt;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
            if (beat_lock) begin
               force_d   = 1'b1;
               force_b_d = a_gnt;
            end
         end
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   // Output logic: grant selection and memory pin drive
   always_comb begin
      win_a      = 1'b0;
      win_b      = 1'b0;
      a_gnt      = 1'b0;
      b_gnt      = 1'b0;
      dm_we      = 1'b0;
      dm_address = '0;
      dm_d       = '0;
      unique case (state_q)
         IDLE: begin
            if (force_q && force_b_q && b_req) begin
               win_b = 1'b1;
            end else if (force_q && !force_b_q && a_req) begin
               win_a = 1'b1;
            end else if (a_req && b_req) begin
`ifdef DM_ARB_RR_EN
               win_a = last_q;
               win_b = !last_q;
`else
               win_a = 1'b1;
`endif
            end else begin
               win_a = a_req;
               win_b = b_req;
            end
         end
         OWN_A:   win_a = a_req;
         OWN_B:   win_b = b_req;
         default: ;
      endcase
      a_gnt = win_a && rst_n;
      b_gnt = win_b && rst_n;
      if (a_gnt) begin
         dm_we      = a_we;
         dm_address = a_addr;
         dm_d       = a_wdata;
      end else if (b_gnt) begin
         dm_we      = b_we;
         dm_address = b_addr;
         dm_d       = b_wdata;
      end
   end

   // Read-data return, one cycle after the granted read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         a_rvalid_q <= a_gnt && !a_we;
         b_rvalid_q <= b_gnt && !b_we;
         if (a_gnt && !a_we) a_rdata_q <= dm_q;
         if (b_gnt && !b_we) b_rdata_q <= dm_q;
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dm_arbiter;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 16;
   localparam int unsigned MAXB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          dm_we;
   logic [AW-1:0] dm_address;
   logic [DW-1:0] dm_d, dm_q;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] mem  [0:65535];
   logic [DW-1:0] mmem [0:65535];

   // Model state: owner 0 none / 1 A / 2 B, favoured port after forced release
   int   m_own, m_beats, m_fav;
   logic m_last_b;
   logic m_rva, m_rvb;
   logic [DW-1:0] m_rda, m_rdb;

   always #5 clk = ~clk;

   assign dm_q = mem[dm_address];
   always @(posedge clk) if (dm_we) mem[dm_address] <= dm_d;

   dm_arbiter #(.DATA_SIZE(DW), .SELEC_SIZE(AW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .dm_we(dm_we), .dm_address(dm_address), .dm_d(dm_d), .dm_q(dm_q)
   );

   task automatic model_reset();
      m_own = 0; m_beats = 0; m_fav = 0; m_last_b = 1'b1;
      m_rva = 1'b0; m_rvb = 1'b0; m_rda = '0; m_rdb = '0;
   endtask

   task automatic model_grant(output logic ea, output logic eb);
      ea = 1'b0; eb = 1'b0;
      if (!rst_n) return;
      if (m_own == 1) ea = a_req;
      else if (m_own == 2) eb = b_req;
      else if (m_fav == 2 && b_req) eb = 1'b1;
      else if (m_fav == 1 && a_req) ea = 1'b1;
      else if (a_req && b_req) begin
`ifdef DM_ARB_RR_EN
         if (m_last_b) ea = 1'b1; else eb = 1'b1;
`else
         ea = 1'b1;
`endif
      end else begin
         ea = a_req; eb = b_req;
      end
   endtask

   task automatic model_clock(input logic ea, input logic eb);
      int   port, beats;
      logic lock;
      if (!rst_n) begin model_reset(); return; end
      m_rva = ea && !a_we;
      m_rvb = eb && !b_we;
      if (m_rva) m_rda = mmem[a_addr];
      if (m_rvb) m_rdb = mmem[b_addr];
      if (ea && a_we) mmem[a_addr] = a_wdata;
      if (eb && b_we) mmem[b_addr] = b_wdata;
      m_fav = 0;
      if (ea || eb) begin
         port  = ea ? 1 : 2;
         lock  = ea ? a_lock : b_lock;
         beats = (m_own == port) ? m_beats + 1 : 1;
         m_last_b = eb;
         if (lock && beats < int'(MAXB)) begin
            m_own = port; m_beats = beats;
         end else begin
            m_own = 0; m_beats = 0;
            if (lock) m_fav = ea ? 2 : 1;
         end
      end else begin
         m_own = 0; m_beats = 0;
      end
   endtask

   task automatic idle_inputs();
      a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
   endtask

   // Leaves the bench 1 time unit after a posedge with reset released
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      a_req = 1; b_req = 1; a_we = 1; b_we = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({a_gnt, b_gnt, dm_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gnt cyc%0d got a_gnt=%b b_gnt=%b dm_we=%b exp 0 0 0", i, a_gnt, b_gnt, dm_we);
         end
         @(posedge clk);
      end
      #1 rst_n = 1'b1; idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({a_rvalid, b_rvalid} !== 2'b00 || a_rdata !== '0 || b_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_rdata got rv=%b%b a=%h b=%h exp 00 0 0", a_rvalid, b_rvalid, a_rdata, b_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      do_reset();
      a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (a_gnt !== 1'b1 || dm_we !== 1'b1 || dm_address !== 16'h0010 || dm_d !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_pins got gnt=%b we=%b addr=%h d=%h exp 1 1 0010 deadbeef", a_gnt, dm_we, dm_address, dm_d);
      end
      @(posedge clk); #1 a_we = 0;
      @(negedge clk);
      n_checks++;
      if (a_gnt !== 1'b1 || dm_we !== 1'b0 || a_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_issue got gnt=%b we=%b rvalid=%b exp 1 0 0", a_gnt, dm_we, a_rvalid);
      end
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_return got a_rv=%b a_rdata=%h b_rv=%b exp 1 deadbeef 0", a_rvalid, a_rdata, b_rvalid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF || dm_address !== '0) begin
         n_fail++;
         $display("FAIL rd_hold got a_rv=%b a_rdata=%h addr=%h exp 0 deadbeef 0", a_rvalid, a_rdata, dm_address);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_conflict();
      logic exp_a;
      do_reset();
      a_req = 1; b_req = 1; a_addr = 16'h0001; b_addr = 16'h0002;
      for (int i = 0; i < 6; i++) begin
`ifdef DM_ARB_RR_EN
         exp_a = (i % 2 == 0);
`else
         exp_a = 1'b1;
`endif
         @(negedge clk);
         n_checks++;
         if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
            n_fail++;
            $display("FAIL conflict cyc%0d got a=%b b=%b exp a=%b b=%b", i, a_gnt, b_gnt, exp_a, !exp_a);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_burst_cap();
      do_reset();
      b_req = 1; b_lock = 1; b_we = 1; b_addr = 16'h0020;
      for (int i = 0; i < 10; i++) begin
         b_wdata = 32'(i);
         @(negedge clk);
         n_checks++;
         if (i < 8 && (b_gnt !== 1'b1 || a_gnt !== 1'b0)) begin
            n_fail++;
            $display("FAIL burst_b cyc%0d got a=%b b=%b exp a=0 b=1", i, a_gnt, b_gnt);
         end else if (i == 8 && (a_gnt !== 1'b1 || b_gnt !== 1'b0)) begin
            n_fail++;
            $display("FAIL burst_release got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt);
         end else if (i == 9 && (b_gnt !== 1'b1 || a_gnt !== 1'b0)) begin
            n_fail++;
            $display("FAIL burst_after got a=%b b=%b exp a=0 b=1", a_gnt, b_gnt);
         end
         @(posedge clk); #1;
         if (i == 0) begin a_req = 1; a_addr = 16'h0020; end
         if (i == 8) a_req = 0;
      end
      idle_inputs();
   endtask

   task automatic test_lock_drop();
      do_reset();
      a_req = 1; a_lock = 1; a_addr = 16'h0010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (i < 3 && (a_gnt !== 1'b1 || b_gnt !== 1'b0)) begin
            n_fail++;
            $display("FAIL lock_own cyc%0d got a=%b b=%b exp a=1 b=0", i, a_gnt, b_gnt);
         end else if (i == 3 && (a_gnt !== 1'b0 || b_gnt !== 1'b0)) begin
            n_fail++;
            $display("FAIL lock_drop got a=%b b=%b exp a=0 b=0", a_gnt, b_gnt);
         end else if (i == 4 && (b_gnt !== 1'b1 || a_gnt !== 1'b0)) begin
            n_fail++;
            $display("FAIL lock_pending_b got a=%b b=%b exp a=0 b=1", a_gnt, b_gnt);
         end
         @(posedge clk); #1;
         if (i == 0) begin b_req = 1; b_addr = 16'h0030; end
         if (i == 2) begin a_req = 0; a_lock = 0; end
      end
      idle_inputs();
   endtask

   task automatic test_reset_midburst();
      do_reset();
      a_req = 1; a_lock = 1; a_addr = 16'h0010;
      repeat (2) begin @(posedge clk); end
      #1 rst_n = 1'b0; a_we = 1; a_wdata = 32'h12345678;
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b1 || a_gnt !== 1'b0 || dm_we !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_gate got rv=%b gnt=%b we=%b exp 1 0 0", a_rvalid, a_gnt, dm_we);
      end
      @(posedge clk);
      #1 rst_n = 1'b1; idle_inputs(); b_req = 1; b_addr = 16'h0010;
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b1 || mem[16'h0010] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL midrst_idle got rv=%b a=%b b=%b mem=%h exp 0 0 1 deadbeef", a_rvalid, a_gnt, b_gnt, mem[16'h0010]);
      end
      @(posedge clk); #1 idle_inputs();
   endtask

   task automatic test_random();
      logic ea, eb, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_d;
      logic saw_a, saw_b;
      for (int k = 0; k < 65536; k++) mmem[k] = mem[k];
      do_reset();
      saw_a = 0; saw_b = 0;
      for (int i = 0; i < 400; i++) begin
         if (!(a_req && !saw_a)) begin
            a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1) != 0;
            a_lock = ($urandom_range(0, 9) < 7); a_addr = 16'h0100 + 16'($urandom_range(0, 15));
            a_wdata = $urandom;
         end
         if (!(b_req && !saw_b)) begin
            b_req = ($urandom_range(0, 3) != 0); b_we = $urandom_range(0, 1) != 0;
            b_lock = ($urandom_range(0, 9) < 7); b_addr = 16'h0100 + 16'($urandom_range(0, 15));
            b_wdata = $urandom;
         end
         @(negedge clk);
         model_grant(ea, eb);
         e_we = ea ? a_we : (eb ? b_we : 1'b0);
         e_addr = ea ? a_addr : (eb ? b_addr : '0);
         e_d = ea ? a_wdata : (eb ? b_wdata : '0);
         saw_a = a_gnt; saw_b = b_gnt;
         n_checks++;
         if (a_gnt !== ea || b_gnt !== eb) begin
            n_fail++;
            $display("FAIL rand_gnt cyc%0d got a=%b b=%b exp a=%b b=%b", i, a_gnt, b_gnt, ea, eb);
         end
         n_checks++;
         if (dm_we !== e_we || dm_address !== e_addr || dm_d !== e_d) begin
            n_fail++;
            $display("FAIL rand_pins cyc%0d got we=%b addr=%h d=%h exp %b %h %h", i, dm_we, dm_address, dm_d, e_we, e_addr, e_d);
         end
         n_checks++;
         if (a_rvalid !== m_rva || a_rdata !== m_rda) begin
            n_fail++;
            $display("FAIL rand_a_rd cyc%0d got rv=%b d=%h exp %b %h", i, a_rvalid, a_rdata, m_rva, m_rda);
         end
         n_checks++;
         if (b_rvalid !== m_rvb || b_rdata !== m_rdb) begin
            n_fail++;
            $display("FAIL rand_b_rd cyc%0d got rv=%b d=%h exp %b %h", i, b_rvalid, b_rdata, m_rvb, m_rdb);
         end
         @(posedge clk);
         model_clock(ea, eb);
         #1;
      end
      idle_inputs();
   endtask

   initial begin
      for (int k = 0; k < 65536; k++) mem[k] = '0;
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #2;
      test_reset();
      test_write_read();
      test_conflict();
      test_burst_cap();
      test_lock_drop();
      test_reset_midburst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1);
   end

endmodule
